// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states and port-owner encoding.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SERV_IF,
    SERV_D,
    ABORT
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_t;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Service watchdog: counts busy cycles while an access is in service and flags expiry
// on the TIMEOUT-th busy edge. Only instantiated when MEM_TIMEOUT_EN is defined.
module mem_arb_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic active,
  input  logic busy,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (!active) begin
      count <= '0;
    end else if (busy && (count != CW'(TIMEOUT))) begin
      count <= count + CW'(1);
    end
  end

  assign expired = active && busy && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and data access.
// Optional busy timeout with sticky err is enabled by defining MEM_TIMEOUT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NBITS   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             if_req,
  input  logic [NBITS-1:0] if_addr,
  output logic             if_done,
  output logic [NBITS-1:0] if_rdata,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [NBITS-1:0] d_addr,
  input  logic [NBITS-1:0] d_wdata,
  output logic             d_done,
  output logic [NBITS-1:0] d_rdata,
  output logic [NBITS-1:0] mem_addr,
  output logic [NBITS-1:0] mem_wdata,
  output logic             MemRead,
  output logic             MemWrite,
  input  logic             busy,
  input  logic [NBITS-1:0] mem_rdata,
  output logic             stall,
  output logic             err
);

  arb_state_t       state, state_nxt;
  owner_t           last_owner, last_owner_nxt;
  logic [NBITS-1:0] mem_addr_nxt, mem_wdata_nxt, if_rdata_nxt, d_rdata_nxt;
  logic             mem_read_nxt, mem_write_nxt, if_done_nxt, d_done_nxt;

`ifdef MEM_TIMEOUT_EN
  logic expired;
  logic err_nxt;

  mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .active  ((state == SERV_IF) || (state == SERV_D)),
    .busy    (busy),
    .expired (expired)
  );
`else
  // TIMEOUT only matters with the watchdog; keep it referenced so the default build is lint-clean.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign err = 1'b0;
`endif

  assign stall = (if_req | d_req) & ~(if_done | d_done);

  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;
    mem_read_nxt   = MemRead;
    mem_write_nxt  = MemWrite;
    if_done_nxt    = 1'b0;
    d_done_nxt     = 1'b0;
    if_rdata_nxt   = if_rdata;
    d_rdata_nxt    = d_rdata;
`ifdef MEM_TIMEOUT_EN
    err_nxt        = err;
`endif
    case (state)
      IDLE: begin
        mem_read_nxt  = 1'b0;
        mem_write_nxt = 1'b0;
        // D has priority unless it owned the port last time, so neither side starves.
        if (d_req && (!if_req || (last_owner == OWN_IF))) begin
          state_nxt     = SERV_D;
          mem_addr_nxt  = d_addr;
          mem_wdata_nxt = d_wdata;
          mem_read_nxt  = ~d_we;
          mem_write_nxt = d_we;
        end else if (if_req) begin
          state_nxt     = SERV_IF;
          mem_addr_nxt  = if_addr;
          mem_wdata_nxt = '0;
          mem_read_nxt  = 1'b1;
        end
      end
      SERV_IF: begin
        if (!busy) begin
          state_nxt      = IDLE;
          last_owner_nxt = OWN_IF;
          if_done_nxt    = 1'b1;
          if_rdata_nxt   = mem_rdata;
          mem_addr_nxt   = '0;
          mem_wdata_nxt  = '0;
          mem_read_nxt   = 1'b0;
          mem_write_nxt  = 1'b0;
        end
`ifdef MEM_TIMEOUT_EN
        else if (expired) begin
          state_nxt      = ABORT;
          last_owner_nxt = OWN_IF;
          if_done_nxt    = 1'b1;
          if_rdata_nxt   = '0;
          err_nxt        = 1'b1;
          mem_addr_nxt   = '0;
          mem_wdata_nxt  = '0;
          mem_read_nxt   = 1'b0;
          mem_write_nxt  = 1'b0;
        end
`endif
      end
      SERV_D: begin
        if (!busy) begin
          state_nxt      = IDLE;
          last_owner_nxt = OWN_D;
          d_done_nxt     = 1'b1;
          if (!MemWrite) begin
            d_rdata_nxt = mem_rdata;
          end
          mem_addr_nxt   = '0;
          mem_wdata_nxt  = '0;
          mem_read_nxt   = 1'b0;
          mem_write_nxt  = 1'b0;
        end
`ifdef MEM_TIMEOUT_EN
        else if (expired) begin
          state_nxt      = ABORT;
          last_owner_nxt = OWN_D;
          d_done_nxt     = 1'b1;
          d_rdata_nxt    = '0;
          err_nxt        = 1'b1;
          mem_addr_nxt   = '0;
          mem_wdata_nxt  = '0;
          mem_read_nxt   = 1'b0;
          mem_write_nxt  = 1'b0;
        end
`endif
      end
      default: begin
        state_nxt     = IDLE;
        mem_read_nxt  = 1'b0;
        mem_write_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= OWN_IF;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      if_done    <= 1'b0;
      d_done     <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
`ifdef MEM_TIMEOUT_EN
      err        <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      MemRead    <= mem_read_nxt;
      MemWrite   <= mem_write_nxt;
      if_done    <= if_done_nxt;
      d_done     <= d_done_nxt;
      if_rdata   <= if_rdata_nxt;
      d_rdata    <= d_rdata_nxt;
`ifdef MEM_TIMEOUT_EN
      err        <= err_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter; covers the timeout path when MEM_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

  logic       clock = 1'b0;
  logic       reset;
  logic       if_req, d_req, d_we, busy;
  logic [7:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic       if_done, d_done, MemRead, MemWrite, stall, err;
  logic [7:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  int vectors = 0;
  int miscompares = 0;

  mem_port_arbiter #(.NBITS(8), .TIMEOUT(15)) dut (
    .clock     (clock),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_done   (if_done),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_done    (d_done),
    .d_rdata   (d_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .busy      (busy),
    .mem_rdata (mem_rdata),
    .stall     (stall),
    .err       (err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    if_req = 0; d_req = 0; d_we = 0; busy = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    repeat (2) @(posedge clock);
    #1;
    vectors++;
    if ({MemRead, MemWrite, if_done, d_done, stall, err} !== 6'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got %b expected 000000", {MemRead, MemWrite, if_done, d_done, stall, err});
    end
    vectors++;
    if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: got %h expected 00000000", {mem_addr, mem_wdata, if_rdata, d_rdata});
    end
    #3 reset = 1'b0;
    tick();
    vectors++;
    if ({MemRead, MemWrite, if_done, d_done} !== 4'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_idle: got %b expected 0000", {MemRead, MemWrite, if_done, d_done});
    end
  endtask

  task automatic test_if_only();
    if_req = 1; if_addr = 8'h04; busy = 0; mem_rdata = 8'h13;
    tick();
    vectors++;
    if ({MemRead, MemWrite, mem_addr, if_done, stall} !== {1'b1, 1'b0, 8'h04, 1'b0, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL if_serv: got rd=%b wr=%b addr=%h done=%b stall=%b expected 1 0 04 0 1",
               MemRead, MemWrite, mem_addr, if_done, stall);
    end
    tick();
    vectors++;
    if ({if_done, d_done, if_rdata, MemRead, stall} !== {1'b1, 1'b0, 8'h13, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL if_done: got done=%b d_done=%b rdata=%h rd=%b stall=%b expected 1 0 13 0 0",
               if_done, d_done, if_rdata, MemRead, stall);
    end
    if_req = 0;
    tick();
    vectors++;
    if ({if_done, if_rdata, MemRead} !== {1'b0, 8'h13, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL if_hold: got done=%b rdata=%h rd=%b expected 0 13 0", if_done, if_rdata, MemRead);
    end
  endtask

  task automatic test_arbitration();
    if_req = 1; if_addr = 8'h30; d_req = 1; d_we = 0; d_addr = 8'h20; mem_rdata = 8'h55;
    tick();
    vectors++;
    if ({MemRead, MemWrite, mem_addr} !== {1'b1, 1'b0, 8'h20}) begin
      miscompares++;
      $display("[TB] FAIL arb_d_first: got rd=%b wr=%b addr=%h expected 1 0 20", MemRead, MemWrite, mem_addr);
    end
    tick();
    vectors++;
    if ({d_done, if_done, d_rdata, MemRead} !== {1'b1, 1'b0, 8'h55, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL arb_d_done: got d=%b i=%b rdata=%h rd=%b expected 1 0 55 0", d_done, if_done, d_rdata, MemRead);
    end
    d_req = 0; mem_rdata = 8'h66;
    tick();
    vectors++;
    if ({MemRead, mem_addr} !== {1'b1, 8'h30}) begin
      miscompares++;
      $display("[TB] FAIL arb_if_second: got rd=%b addr=%h expected 1 30", MemRead, mem_addr);
    end
    d_req = 1; d_addr = 8'h21;
    #1;
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL arb_wait_stall: got %b expected 1", stall);
    end
    tick();
    vectors++;
    if ({if_done, d_done, if_rdata, d_rdata} !== {1'b1, 1'b0, 8'h66, 8'h55}) begin
      miscompares++;
      $display("[TB] FAIL arb_if_done: got i=%b d=%b if_rdata=%h d_rdata=%h expected 1 0 66 55",
               if_done, d_done, if_rdata, d_rdata);
    end
    if_req = 0; mem_rdata = 8'h77;
    tick();
    vectors++;
    if ({MemRead, mem_addr} !== {1'b1, 8'h21}) begin
      miscompares++;
      $display("[TB] FAIL arb_d_waited: got rd=%b addr=%h expected 1 21", MemRead, mem_addr);
    end
    tick();
    vectors++;
    if ({d_done, d_rdata, if_rdata} !== {1'b1, 8'h77, 8'h66}) begin
      miscompares++;
      $display("[TB] FAIL arb_d_waited_done: got d=%b d_rdata=%h if_rdata=%h expected 1 77 66", d_done, d_rdata, if_rdata);
    end
    d_req = 0;
    tick();
    // Last owner is now D, so simultaneous requests must go to IF first.
    if_req = 1; if_addr = 8'h34; d_req = 1; d_addr = 8'h24; mem_rdata = 8'h88;
    tick();
    vectors++;
    if ({MemRead, mem_addr} !== {1'b1, 8'h34}) begin
      miscompares++;
      $display("[TB] FAIL arb_if_first: got rd=%b addr=%h expected 1 34", MemRead, mem_addr);
    end
    tick();
    vectors++;
    if ({if_done, d_done, if_rdata} !== {1'b1, 1'b0, 8'h88}) begin
      miscompares++;
      $display("[TB] FAIL arb_if_first_done: got i=%b d=%b rdata=%h expected 1 0 88", if_done, d_done, if_rdata);
    end
    if_req = 0;
    tick();
    vectors++;
    if ({MemRead, mem_addr} !== {1'b1, 8'h24}) begin
      miscompares++;
      $display("[TB] FAIL arb_d_second: got rd=%b addr=%h expected 1 24", MemRead, mem_addr);
    end
    tick();
    vectors++;
    if ({d_done, d_rdata} !== {1'b1, 8'h88}) begin
      miscompares++;
      $display("[TB] FAIL arb_d_second_done: got d=%b rdata=%h expected 1 88", d_done, d_rdata);
    end
    d_req = 0;
    tick();
  endtask

  task automatic test_store_busy();
    d_req = 1; d_we = 1; d_addr = 8'h10; d_wdata = 8'hAA; busy = 1; mem_rdata = 8'hEE;
    tick();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({MemWrite, MemRead, mem_addr, mem_wdata, stall, d_done} !== {1'b1, 1'b0, 8'h10, 8'hAA, 1'b1, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL store_hold[%0d]: got wr=%b rd=%b addr=%h wdata=%h stall=%b done=%b expected 1 0 10 aa 1 0",
                 i, MemWrite, MemRead, mem_addr, mem_wdata, stall, d_done);
      end
      if (i == 3) busy = 0;
      tick();
    end
    vectors++;
    if ({d_done, MemWrite, d_rdata} !== {1'b1, 1'b0, 8'h88}) begin
      miscompares++;
      $display("[TB] FAIL store_done: got done=%b wr=%b d_rdata=%h expected 1 0 88", d_done, MemWrite, d_rdata);
    end
    d_req = 0; d_we = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    int cycles;
    d_req = 1; d_we = 0; d_addr = 8'h50; busy = 1; mem_rdata = 8'h5A;
    tick();
    tick();
    vectors++;
    if ({MemRead, mem_addr} !== {1'b1, 8'h50}) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_serv: got rd=%b addr=%h expected 1 50", MemRead, mem_addr);
    end
    #2 reset = 1; d_req = 0; busy = 0;
    #1;
    vectors++;
    if ({MemRead, MemWrite, mem_addr, d_rdata, if_rdata, d_done} !== {1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_async: got rd=%b wr=%b addr=%h d_rdata=%h if_rdata=%h done=%b expected all 0",
               MemRead, MemWrite, mem_addr, d_rdata, if_rdata, d_done);
    end
    tick();
    #3 reset = 0;
    tick();
    vectors++;
    if ({d_done, MemRead} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_no_done: got done=%b rd=%b expected 0 0", d_done, MemRead);
    end
    if_req = 1; if_addr = 8'h08; mem_rdata = 8'h42;
    cycles = 0;
    while (!if_done && cycles < 10) begin
      tick();
      cycles++;
    end
    vectors++;
    if ({if_done, if_rdata, 8'(cycles)} !== {1'b1, 8'h42, 8'd2}) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_next: got done=%b rdata=%h cycles=%0d expected 1 42 2", if_done, if_rdata, cycles);
    end
    if_req = 0;
    tick();
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    d_req = 1; d_we = 0; d_addr = 8'h40; busy = 1; mem_rdata = 8'h99;
    tick();
    for (int i = 1; i <= 15; i++) begin
      vectors++;
      if ({MemRead, err, d_done} !== 3'b100) begin
        miscompares++;
        $display("[TB] FAIL timeout_wait[%0d]: got rd=%b err=%b done=%b expected 1 0 0", i, MemRead, err, d_done);
      end
      tick();
    end
    vectors++;
    if ({MemRead, MemWrite, err, d_done, d_rdata} !== {1'b0, 1'b0, 1'b1, 1'b1, 8'h00}) begin
      miscompares++;
      $display("[TB] FAIL timeout_abort: got rd=%b wr=%b err=%b done=%b rdata=%h expected 0 0 1 1 00",
               MemRead, MemWrite, err, d_done, d_rdata);
    end
    d_req = 0; busy = 0;
    tick();
    if_req = 1; if_addr = 8'h0C; mem_rdata = 8'h3C;
    tick();
    tick();
    vectors++;
    if ({if_done, if_rdata, err} !== {1'b1, 8'h3C, 1'b1}) begin
      miscompares++;
      $display("[TB] FAIL timeout_sticky: got done=%b rdata=%h err=%b expected 1 3c 1", if_done, if_rdata, err);
    end
    if_req = 0;
    tick();
  endtask
`else
  task automatic test_no_timeout();
    d_req = 1; d_we = 0; d_addr = 8'h40; busy = 1; mem_rdata = 8'h99;
    repeat (21) tick();
    vectors++;
    if ({MemRead, mem_addr, err, d_done} !== {1'b1, 8'h40, 1'b0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL no_timeout_wait: got rd=%b addr=%h err=%b done=%b expected 1 40 0 0", MemRead, mem_addr, err, d_done);
    end
    busy = 0;
    tick();
    vectors++;
    if ({d_done, d_rdata, err} !== {1'b1, 8'h99, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL no_timeout_done: got done=%b rdata=%h err=%b expected 1 99 0", d_done, d_rdata, err);
    end
    d_req = 0;
    tick();
  endtask
`endif

  task automatic test_alternation();
    int   served;
    logic expect_d;
    #2 reset = 1;
    tick();
    #3 reset = 0;
    tick();
    served = 0;
    expect_d = 1'b1;
    busy = 0; d_we = 0; if_addr = 8'h60; d_addr = 8'h70; mem_rdata = 8'h11;
    if_req = 1; d_req = 1;
    for (int c = 0; c < 200 && served < 20; c++) begin
      tick();
      if (if_done || d_done) begin
        vectors++;
        if ({if_done, d_done} !== {~expect_d, expect_d}) begin
          miscompares++;
          $display("[TB] FAIL alt_order[%0d]: got if_done=%b d_done=%b expected %b %b",
                   served, if_done, d_done, ~expect_d, expect_d);
        end
        expect_d = ~expect_d;
        served++;
      end
      if_req = ~if_done;
      d_req = ~d_done;
    end
    vectors++;
    if (served !== 20) begin
      miscompares++;
      $display("[TB] FAIL alt_count: got %0d transactions expected 20", served);
    end
    if_req = 0; d_req = 0;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_if_only();
    test_arbitration();
    test_store_busy();
    test_reset_mid();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_alternation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
